// File: rtl/rom_port_arbiter_pkg.sv
// Shared encodings for the ROM port arbiter: FSM states, owner tags and the
// encoder busy-handshake timeout.
package rom_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

  // Cycles from one enc_request pulse to the re-pulse when busy never rises.
  localparam int BUSY_TIMEOUT = 8;
  localparam int TIMEOUT_W    = $clog2(BUSY_TIMEOUT);

  localparam logic OWNER_A = 1'b1;
  localparam logic OWNER_B = 1'b0;

endpackage

// File: rtl/rom_port_arbiter_rr.sv
// Two-way grant decision: A has priority unless A held the previous grant
// and B is also eligible, which makes contended grants alternate.
module rr_arbiter_2
  import rom_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic a_elig,
  input  logic b_elig,
  input  logic commit,
  output logic any_elig,
  output logic grant_a
);

  logic last_owner_q;
  logic last_owner_d;

  assign any_elig = a_elig | b_elig;
  assign grant_a  = a_elig & ~((last_owner_q == OWNER_A) & b_elig);

  always_comb begin
    last_owner_d = last_owner_q;
    if (commit && any_elig) begin
      last_owner_d = grant_a ? OWNER_A : OWNER_B;
    end
  end

  // Starting from "last = B" lets A win the first contended grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_owner_q <= OWNER_B;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the ROM encoder port between the stream loader (writes, port A) and
// CPU instruction fetch (reads, port B) with a request/busy/done sequencer.
module rom_port_arbiter
  import rom_port_arbiter_pkg::*;
#(
  parameter int WORD_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     a_req,
  input  logic [ADDRESS_WIDTH-1:0] a_addr,
  input  logic [WORD_WIDTH-1:0]    a_wdata,
  input  logic                     a_lock,
  output logic                     a_ack,
  input  logic                     b_req,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  output logic                     b_ack,
  output logic [WORD_WIDTH-1:0]    b_rdata,
  output logic                     cpu_hold,
  input  logic                     enc_initialized,
  input  logic                     enc_busy,
  output logic                     enc_request,
  output logic [ADDRESS_WIDTH-1:0] enc_address,
  output logic                     enc_write_enable,
  output logic [WORD_WIDTH-1:0]    enc_wdata,
  input  logic [WORD_WIDTH-1:0]    enc_rdata,
  output logic [ADDRESS_WIDTH:0]   load_count
);

  localparam int CNT_W = ADDRESS_WIDTH + 1;

  arb_state_e                 state_q, state_d;
  logic [TIMEOUT_W-1:0]       tmo_q, tmo_d;
  logic                       owner_q, owner_d;
  logic                       enc_request_q, enc_request_d;
  logic [ADDRESS_WIDTH-1:0]   enc_address_q, enc_address_d;
  logic                       enc_we_q, enc_we_d;
  logic [WORD_WIDTH-1:0]      enc_wdata_q, enc_wdata_d;
  logic                       a_ack_q, a_ack_d;
  logic                       b_ack_q, b_ack_d;
  logic [WORD_WIDTH-1:0]      b_rdata_q, b_rdata_d;
  logic [CNT_W-1:0]           load_count_q, load_count_d;

  logic grant_commit;
  logic any_elig;
  logic grant_a;

  rr_arbiter_2 u_rr (
    .clk      (clk),
    .reset_n  (reset_n),
    .a_elig   (a_req),
    .b_elig   (b_req & ~a_lock),
    .commit   (grant_commit),
    .any_elig (any_elig),
    .grant_a  (grant_a)
  );

  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    owner_d       = owner_q;
    enc_address_d = enc_address_q;
    enc_we_d      = enc_we_q;
    enc_wdata_d   = enc_wdata_q;
    a_ack_d       = 1'b0;
    b_ack_d       = 1'b0;
    b_rdata_d     = b_rdata_q;
    load_count_d  = load_count_q;
    grant_commit  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The ack cycle is skipped: the requester still holds its req then.
        if (enc_initialized && !enc_busy && !a_ack_q && !b_ack_q && any_elig) begin
          grant_commit  = 1'b1;
          owner_d       = grant_a ? OWNER_A : OWNER_B;
          enc_address_d = grant_a ? a_addr : b_addr;
          enc_wdata_d   = grant_a ? a_wdata : '0;
          enc_we_d      = grant_a;
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmo_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (enc_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (tmo_q == TIMEOUT_W'(BUSY_TIMEOUT - 2)) begin
          state_d = ST_ISSUE;
        end else begin
          tmo_d = tmo_q + TIMEOUT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!enc_busy) begin
          if (owner_q == OWNER_B) begin
            b_rdata_d = enc_rdata;
            b_ack_d   = 1'b1;
          end else begin
            a_ack_d = 1'b1;
            if (load_count_q != '1) begin
              load_count_d = load_count_q + CNT_W'(1);
            end
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    enc_request_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      tmo_q         <= '0;
      owner_q       <= OWNER_B;
      enc_request_q <= 1'b0;
      enc_address_q <= '0;
      enc_we_q      <= 1'b0;
      enc_wdata_q   <= '0;
      a_ack_q       <= 1'b0;
      b_ack_q       <= 1'b0;
      b_rdata_q     <= '0;
      load_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      owner_q       <= owner_d;
      enc_request_q <= enc_request_d;
      enc_address_q <= enc_address_d;
      enc_we_q      <= enc_we_d;
      enc_wdata_q   <= enc_wdata_d;
      a_ack_q       <= a_ack_d;
      b_ack_q       <= b_ack_d;
      b_rdata_q     <= b_rdata_d;
      load_count_q  <= load_count_d;
    end
  end

  assign cpu_hold         = a_lock | ~enc_initialized;
  assign a_ack            = a_ack_q;
  assign b_ack            = b_ack_q;
  assign b_rdata          = b_rdata_q;
  assign enc_request      = enc_request_q;
  assign enc_address      = enc_address_q;
  assign enc_write_enable = enc_we_q;
  assign enc_wdata        = enc_wdata_q;
  assign load_count       = load_count_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter: requester drivers push expectations,
// a negedge monitor pops them on every ack; a small build covers saturation.
module tb_rom_port_arbiter;

  localparam int WW  = 16;
  localparam int AW  = 16;
  localparam int SWW = 8;
  localparam int SAW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          a_req, a_lock, a_ack, b_req, b_ack, cpu_hold;
  logic [AW-1:0] a_addr, b_addr, enc_address;
  logic [WW-1:0] a_wdata, b_rdata, enc_wdata, enc_rdata;
  logic          enc_initialized, enc_busy, enc_request, enc_write_enable;
  logic [AW:0]   load_count;

  rom_port_arbiter #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock), .a_ack(a_ack),
    .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack), .b_rdata(b_rdata),
    .cpu_hold(cpu_hold), .enc_initialized(enc_initialized), .enc_busy(enc_busy),
    .enc_request(enc_request), .enc_address(enc_address),
    .enc_write_enable(enc_write_enable), .enc_wdata(enc_wdata),
    .enc_rdata(enc_rdata), .load_count(load_count)
  );

  // Small build used only for the load counter saturation run.
  logic           s_a_req, s_a_ack, s_b_ack, s_cpu_hold, s_busy, s_enc_request, s_enc_we;
  logic [SAW-1:0] s_a_addr, s_enc_address;
  logic [SWW-1:0] s_b_rdata, s_enc_wdata;
  logic [SAW:0]   s_load_count;

  rom_port_arbiter #(.WORD_WIDTH(SWW), .ADDRESS_WIDTH(SAW)) dut_s (
    .clk(clk), .reset_n(reset_n),
    .a_req(s_a_req), .a_addr(s_a_addr), .a_wdata(8'h5A), .a_lock(1'b0), .a_ack(s_a_ack),
    .b_req(1'b0), .b_addr('0), .b_ack(s_b_ack), .b_rdata(s_b_rdata),
    .cpu_hold(s_cpu_hold), .enc_initialized(1'b1), .enc_busy(s_busy),
    .enc_request(s_enc_request), .enc_address(s_enc_address),
    .enc_write_enable(s_enc_we), .enc_wdata(s_enc_wdata),
    .enc_rdata(8'h00), .load_count(s_load_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Contents of the ROM region the CPU fetches from (never written by port A).
  function automatic logic [15:0] rom_word(input logic [15:0] a);
    if (a == 16'h0005) return 16'hEC10;
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_wr_q[$];
  logic [15:0] exp_b_q[$];
  bit          grant_log[$];
  logic [AW:0] exp_load = '0;
  bit          lock_phase = 1'b0;
  bit          enc_mute = 1'b0;
  int          wr_issued = 0;

  // Encoder model: accepts a request, raises busy after 1-3 cycles, keeps it
  // for 1-4 cycles, and presents read data as busy falls.
  initial begin
    logic [15:0] ad;
    logic        we;
    enc_busy  = 1'b0;
    enc_rdata = '0;
    forever begin
      @(negedge clk);
      if (enc_request && !enc_mute && reset_n) begin
        ad = enc_address;
        we = enc_write_enable;
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
        enc_busy = 1'b1;
        repeat (1 + $urandom_range(0, 3)) @(negedge clk);
        check("enc_addr_stable", enc_address, ad);
        if (!we) enc_rdata = rom_word(ad);
        enc_busy = 1'b0;
      end
    end
  end

  initial begin
    s_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (s_enc_request && reset_n) begin
        @(negedge clk);
        s_busy = 1'b1;
        @(negedge clk);
        s_busy = 1'b0;
      end
    end
  end

  // Monitor: every ack pops the oldest expectation for its port.
  initial begin
    wr_t         w;
    logic [15:0] r;
    forever begin
      @(negedge clk);
      if (!reset_n) continue;
      if (a_ack && b_ack) check("ack_exclusive", 32'd1, 32'd0);
      if (lock_phase) begin
        check("cpu_hold_lock", cpu_hold, 1'b1);
        if (b_ack) check("b_grant_in_lock", b_ack, 1'b0);
      end
      if (a_ack) begin
        if (exp_wr_q.size() == 0) begin
          check("a_ack_unexpected", a_ack, 1'b0);
        end else begin
          w = exp_wr_q.pop_front();
          check("a_enc_addr", enc_address, w.addr);
          check("a_enc_wdata", enc_wdata, w.data);
          check("a_enc_we", enc_write_enable, 1'b1);
        end
        if (exp_load != '1) exp_load = exp_load + 1'b1;
        check("load_count", load_count, exp_load);
        grant_log.push_back(1'b1);
      end
      if (b_ack) begin
        if (exp_b_q.size() == 0) begin
          check("b_ack_unexpected", b_ack, 1'b0);
        end else begin
          r = exp_b_q.pop_front();
          check("b_rdata", b_rdata, r);
          check("b_enc_we", enc_write_enable, 1'b0);
        end
        grant_log.push_back(1'b0);
      end
    end
  end

  task automatic do_a(input logic [15:0] ad, input logic [15:0] wd);
    int n = 0;
    a_addr  = ad;
    a_wdata = wd;
    exp_wr_q.push_back('{addr: ad, data: wd});
    wr_issued++;
    a_req = 1'b1;
    do begin @(negedge clk); n++; end while (!a_ack && n < 400);
    check("a_ack_seen", a_ack, 1'b1);
    a_req = 1'b0;
  endtask

  task automatic do_b(input logic [15:0] ad);
    int n = 0;
    b_addr = ad;
    exp_b_q.push_back(rom_word(ad));
    b_req = 1'b1;
    do begin @(negedge clk); n++; end while (!b_ack && n < 400);
    check("b_ack_seen", b_ack, 1'b1);
    b_req = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int first;
    int pulses;
    int last_t;
    bit saw;
    reset_n = 1'b0; enc_initialized = 1'b0;
    a_req = 1'b0; a_lock = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_addr = '0; s_a_req = 1'b0; s_a_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_enc_request", enc_request, 1'b0);
    check("rst_enc_address", enc_address, '0);
    check("rst_enc_we", enc_write_enable, 1'b0);
    check("rst_enc_wdata", enc_wdata, '0);
    check("rst_acks", {a_ack, b_ack}, 2'b00);
    check("rst_b_rdata", b_rdata, '0);
    check("rst_load_count", load_count, '0);
    check("rst_cpu_hold", cpu_hold, 1'b1);

    // Fetch pending while the encoder is not yet initialized.
    reset_n = 1'b1;
    b_addr = 16'h1003;
    exp_b_q.push_back(rom_word(16'h1003));
    b_req = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (enc_request) saw = 1'b1;
    end
    check("no_req_uninit", saw, 1'b0);
    check("cpu_hold_uninit", cpu_hold, 1'b1);
    enc_initialized = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!enc_request && n < 4);
    check("req_within_2", (enc_request && n <= 2), 1'b1);
    check("cpu_hold_init", cpu_hold, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!b_ack && n < 400);
    check("first_b_ack", b_ack, 1'b1);
    b_req = 1'b0;
    @(negedge clk);
    check("b_ack_one_pulse", b_ack, 1'b0);

    do_b(16'h0005);
    check("fetch_ec10_held", b_rdata, 16'hEC10);

    // Load session: B is held off until the lock drops.
    a_lock = 1'b1;
    lock_phase = 1'b1;
    fork
      do_b(16'h1010);
      begin
        for (int i = 0; i < 4; i++) do_a(16'(i), 16'h1111 * 16'(i + 1));
        check("load_after_lock", load_count, 17'd4);
        lock_phase = 1'b0;
        a_lock = 1'b0;
      end
    join

    // Contended grants alternate, starting with A (last grant was B).
    grant_log.delete();
    fork
      for (int i = 0; i < 4; i++) do_a(16'h0020 + 16'(i), 16'($urandom));
      for (int i = 0; i < 4; i++) do_b(16'h1020 + 16'(i));
    join
    check("alt_log_size", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      check("alt_order", grant_log[i], (i % 2 == 0));

    for (int it = 0; it < 20; it++) begin
      fork
        begin
          int k = $urandom_range(0, 3);
          for (int j = 0; j < k; j++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_a(16'($urandom_range(0, 16'h0FFF)), 16'($urandom));
          end
        end
        begin
          int k = $urandom_range(0, 3);
          for (int j = 0; j < k; j++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_b(16'h1000 | 16'($urandom_range(0, 16'h0FFF)));
          end
        end
      join
    end
    @(negedge clk);
    check("load_total", load_count, 17'(wr_issued));
    check("exp_wr_drained", exp_wr_q.size(), 0);
    check("exp_b_drained", exp_b_q.size(), 0);

    // Encoder never answers: request re-pulses every 8 cycles, no ack.
    enc_mute = 1'b1;
    b_addr = 16'h1234;
    b_req = 1'b1;
    first = -1; last_t = -1; pulses = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (enc_request) begin
        if (last_t >= 0) check("retry_period", t - last_t, 8);
        if (first < 0) first = t;
        last_t = t;
        pulses++;
      end
      if (b_ack) check("ack_while_mute", b_ack, 1'b0);
    end
    check("retry_pulses", (pulses >= 4), 1'b1);
    reset_n = 1'b0;
    #1;
    check("midrst_request", enc_request, 1'b0);
    check("midrst_addr", enc_address, '0);
    check("midrst_acks", {a_ack, b_ack}, 2'b00);
    check("midrst_b_rdata", b_rdata, '0);
    check("midrst_load", load_count, '0);
    b_req = 1'b0;
    exp_load = '0;
    @(negedge clk);
    reset_n = 1'b1;
    saw = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (enc_request || a_ack || b_ack) saw = 1'b1;
    end
    check("idle_after_rst", saw, 1'b0);
    enc_mute = 1'b0;
    do_b(16'h1040);

    // Saturation on the small build: 3-bit counter, 10 writes.
    for (int k = 1; k <= 10; k++) begin
      s_a_addr = 2'(k);
      s_a_req = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!s_a_ack && n < 50);
      check("sat_ack_seen", s_a_ack, 1'b1);
      s_a_req = 1'b0;
      check("sat_count", s_load_count, (k > 7) ? 7 : k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
